// File: rtl/traffic_light_driver.sv
// Two-way traffic light sequencer: GREEN -> YELLOW -> ALLRED -> GREEN between the E+W and N+S
// lane patterns, with all outputs registered and illegal requests flagged for one cycle.
module traffic_light_driver #(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  laneReq,
  output logic [11:0] lightOut,
  output logic [1:0]  phase,
  output logic        invalidReq
);

  localparam logic [7:0]  LanesEw = 8'b11001100;
  localparam logic [7:0]  LanesNs = 8'b00110011;
  localparam logic [2:0]  LampR   = 3'b100;
  localparam logic [2:0]  LampY   = 3'b010;
  localparam logic [2:0]  LampG   = 3'b001;
  localparam logic [11:0] AllRed  = 12'b100100100100;

  localparam int unsigned MaxGy  = (MIN_GREEN > YELLOW_CYCLES) ? MIN_GREEN : YELLOW_CYCLES;
  localparam int unsigned MaxCyc = (MaxGy > ALLRED_CYCLES) ? MaxGy : ALLRED_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] GreenLoad  = CntW'(MIN_GREEN - 1);
  localparam logic [CntW-1:0] YellowLoad = CntW'(YELLOW_CYCLES - 1);
  localparam logic [CntW-1:0] AllRedLoad = CntW'(ALLRED_CYCLES - 1);

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10,
    StBad    = 2'b11
  } state_e;

  state_e          state_q;
  logic [7:0]      active_q;
  logic [7:0]      target_q;
  logic [CntW-1:0] cnt_q;
  logic [11:0]     light_q;
  logic            invalid_q;
  logic            req_legal;

  assign req_legal  = (laneReq == LanesEw) || (laneReq == LanesNs);
  assign lightOut   = light_q;
  assign phase      = state_q;
  assign invalidReq = invalid_q;

  // A direction is lit with 'on' only when both of its lane bits are set; everything else is red.
  function automatic logic [11:0] lamps(input logic [7:0] lanes, input logic [2:0] on);
    logic [11:0] l;
    l = '0;
    for (int d = 0; d < 4; d++) begin
      l[3*d +: 3] = (lanes[2*d +: 2] == 2'b11) ? on : LampR;
    end
    return l;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StGreen;
      active_q  <= LanesEw;
      target_q  <= LanesEw;
      cnt_q     <= GreenLoad;
      light_q   <= lamps(LanesEw, LampG);
      invalid_q <= 1'b0;
    end else begin
      invalid_q <= !req_legal;
      unique case (state_q)
        StGreen: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (req_legal && (laneReq != active_q)) begin
            state_q  <= StYellow;
            target_q <= laneReq;
            cnt_q    <= YellowLoad;
            light_q  <= lamps(active_q, LampY);
          end
        end
        StYellow: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= StAllRed;
            cnt_q   <= AllRedLoad;
            light_q <= AllRed;
          end
        end
        StAllRed: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q  <= StGreen;
            active_q <= target_q;
            cnt_q    <= GreenLoad;
            light_q  <= lamps(target_q, LampG);
          end
        end
        default: begin
          // Recover from the unused encoding through a full clearance phase.
          state_q <= StAllRed;
          cnt_q   <= AllRedLoad;
          light_q <= AllRed;
        end
      endcase
    end
  end

endmodule
